// File: rtl/truth_table_checker_pkg.sv
// Shared types and sizing helpers for the truth-table checker.
// Imported by the interface, the vector sequencer and the top.
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample,
    StDone
  } state_e;

  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // A SETTLE of 1 still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? int'($clog2(settle)) : 1;
  endfunction

  localparam int unsigned DefNIn  = 3;
  localparam int unsigned DefNVec = n_vec(DefNIn);

endpackage

// File: rtl/truth_table_checker_if.sv
// Control, stimulus and result signals of the truth-table checker.
// The checker uses slave; whatever drives start/dut_out uses master.
interface truth_table_checker_if
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned N_VEC = n_vec(N_IN);

  logic             start;
  logic [N_IN-1:0]  vec_out;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_fail;
  logic             first_fail_valid;
  logic [N_VEC-1:0] observed;

  modport master (
    output start, dut_out,
    input  vec_out, busy, done, pass, err_count, first_fail, first_fail_valid, observed
  );

  modport slave (
    input  start, dut_out,
    output vec_out, busy, done, pass, err_count, first_fail, first_fail_valid, observed
  );

endinterface

// File: rtl/truth_table_checker_vec_sequencer.sv
// Holds the applied input vector and the settle counter for the sweep.
// sample_now_o flags the last settle cycle; last_vec_o flags the final vector.
module truth_table_checker_vec_sequencer
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            advance_i,
  input  logic            count_en_i,
  output logic [N_IN-1:0] vec_o,
  output logic            sample_now_o,
  output logic            last_vec_o
);

  localparam int unsigned CntW = cnt_width(SETTLE);

  logic [N_IN-1:0] vec_q, vec_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign vec_o        = vec_q;
  assign sample_now_o = (cnt_q == CntW'(SETTLE - 1));
  assign last_vec_o   = (vec_q == {N_IN{1'b1}});

  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (load_i) begin
      vec_d = '0;
      cnt_d = '0;
    end else if (advance_i) begin
      vec_d = vec_q + 1'b1;
      cnt_d = '0;
    end else if (count_en_i && !sample_now_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a small combinational block, samples its output
// after a settle delay and accumulates mismatches against an expected table.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int unsigned            N_IN     = 3,
  parameter logic [n_vec(N_IN)-1:0] EXPECTED = 8'hE8,
  parameter int unsigned            SETTLE   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_checker_if.slave bus
);

  localparam int unsigned N_VEC = n_vec(N_IN);

  state_e           state_q, state_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  ff_q, ff_d;
  logic             ffv_q, ffv_d;
  logic [N_VEC-1:0] obs_q, obs_d;
  logic             pass_q, pass_d;

  logic            load, advance, count_en;
  logic [N_IN-1:0] vec;
  logic            sample_now, last_vec;

  truth_table_checker_vec_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .advance_i    (advance),
    .count_en_i   (count_en),
    .vec_o        (vec),
    .sample_now_o (sample_now),
    .last_vec_o   (last_vec)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    count_en = 1'b0;
    err_d    = err_q;
    ff_d     = ff_q;
    ffv_d    = ffv_q;
    obs_d    = obs_q;
    pass_d   = pass_q;
    unique case (state_q)
      // DONE behaves like IDLE for start so back-to-back sweeps lose no cycle.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          load    = 1'b1;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          obs_d   = '0;
          pass_d  = 1'b0;
          state_d = StApply;
        end
      end
      StApply: begin
        count_en = 1'b1;
        if (sample_now) state_d = StSample;
      end
      StSample: begin
        obs_d[vec] = bus.dut_out;
        if (bus.dut_out != EXPECTED[vec]) begin
          err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ff_d  = vec;
            ffv_d = 1'b1;
          end
        end
        if (last_vec) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          advance = 1'b1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      obs_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      obs_q   <= obs_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec_out          = vec;
  assign bus.busy             = (state_q == StApply) || (state_q == StSample);
  assign bus.done             = (state_q == StDone);
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.observed         = obs_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: each start pushes the expected sweep result, and a monitor
// pops and compares it whenever done is seen.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(3)) bus ();

  truth_table_checker #(
    .N_IN     (3),
    .EXPECTED (8'hE8),
    .SETTLE   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Block-under-test model: 0 majority, 1 stuck at 0, 2 majority with vector 5 inverted.
  int unsigned mode = 0;
  logic [2:0] v;
  logic       maj;
  logic       model_out;
  assign v   = bus.vec_out;
  assign maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  always_comb begin
    model_out = maj;
    case (mode)
      1:       model_out = 1'b0;
      2:       model_out = maj ^ (v == 3'd5);
      default: model_out = maj;
    endcase
  end
  assign bus.dut_out = model_out;

  typedef struct {
    logic        pass;
    logic [3:0]  err;
    logic [2:0]  ff;
    logic        ffv;
    logic [7:0]  obs;
    int unsigned start_cyc;
  } exp_t;

  exp_t sb[$];
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_err"}, 32'(bus.err_count), 0);
    chk({tag, "_ff"}, 32'(bus.first_fail), 0);
    chk({tag, "_ffv"}, 32'(bus.first_fail_valid), 0);
    chk({tag, "_obs"}, 32'(bus.observed), 0);
    chk({tag, "_vec"}, 32'(bus.vec_out), 0);
  endtask

  // Called at a negedge: start is seen by the next rising edge.
  task automatic issue_start(input logic p, input logic [3:0] e, input logic [2:0] f,
                             input logic fv, input logic [7:0] o);
    exp_t x;
    x.pass = p;
    x.err = e;
    x.ff = f;
    x.ffv = fv;
    x.obs = o;
    x.start_cyc = cyc;
    sb.push_back(x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        chk("done_latency", cyc - x.start_cyc, 25);
        chk("pass", 32'(bus.pass), 32'(x.pass));
        chk("err_count", 32'(bus.err_count), 32'(x.err));
        chk("first_fail", 32'(bus.first_fail), 32'(x.ff));
        chk("first_fail_valid", 32'(bus.first_fail_valid), 32'(x.ffv));
        chk("observed", 32'(bus.observed), 32'(x.obs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Majority sweep; also trace vec_out stepping through 0..7, 3 cycles each.
    mode = 0;
    issue_start(1'b1, 4'd0, 3'd0, 1'b0, 8'hE8);
    for (int k = 0; k < 24; k++) begin
      chk("sweep_busy", 32'(bus.busy), 1);
      chk("sweep_vec", 32'(bus.vec_out), 32'(k / 3));
      @(negedge clk);
    end
    chk("idle_busy", 32'(bus.busy), 0);
    wait_drain(5);

    // Output stuck at 0: mismatches on vectors 3, 5, 6, 7.
    mode = 1;
    issue_start(1'b0, 4'd4, 3'd3, 1'b1, 8'h00);
    wait_drain(40);

    // Vector 5 inverted.
    mode = 2;
    issue_start(1'b0, 4'd1, 3'd5, 1'b1, 8'hC8);
    wait_drain(40);

    // start during a sweep is ignored; a stray second done would underflow the scoreboard.
    mode = 0;
    issue_start(1'b1, 4'd0, 3'd0, 1'b0, 8'hE8);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(40);
    repeat (30) @(negedge clk);

    // Reset in the middle of a sweep: everything clears and no done follows.
    mode = 0;
    issue_start(1'b1, 4'd0, 3'd0, 1'b0, 8'hE8);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("midrst");
    sb.delete();
    repeat (30) @(negedge clk);
    issue_start(1'b1, 4'd0, 3'd0, 1'b0, 8'hE8);
    wait_drain(40);

    // start held in the DONE cycle launches the next sweep immediately.
    mode = 1;
    issue_start(1'b0, 4'd4, 3'd3, 1'b1, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("restart_done_seen", 32'(found), 1);
    mode = 0;
    issue_start(1'b1, 4'd0, 3'd0, 1'b0, 8'hE8);
    chk("restart_busy", 32'(bus.busy), 1);
    chk("restart_err_clr", 32'(bus.err_count), 0);
    chk("restart_obs_clr", 32'(bus.observed), 0);
    chk("restart_ffv_clr", 32'(bus.first_fail_valid), 0);
    wait_drain(40);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
